fir_ctrl_fsm: RTL and testbench
===============================

FIR_CTRL_FSM -- requirements
Module: fir_ctrl_fsm

Interface
REQ-001 SHALL have ports: clk_b  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Start  in  1  level start request from the control registers; the block acts on its rising edge.
REQ-004 SHALL have ports: Ile_wsp  in  6  number of coefficients N (0..63).
REQ-005 SHALL have ports: Ile_probek  in  14  number of samples M (0..16383).
REQ-006 SHALL have ports: Pracuje  out  1  busy flag.
REQ-007 SHALL have ports: DONE  out  1  one-cycle completion pulse.
REQ-008 SHALL have ports: rd_en  out  1  read strobe for sample and coefficient memories; read latency is 1 cycle.
REQ-009 SHALL have ports: adr_probki  out  14  sample memory address.
REQ-010 SHALL have ports: adr_wsp  out  6  coefficient memory address.
REQ-011 SHALL have ports: mac_clr  out  1  clears the MAC accumulator.
REQ-012 SHALL have ports: mac_en  out  1  MAC accumulates the current data pair.
REQ-013 SHALL have ports: wr_wynik  out  1  result memory write strobe.
REQ-014 SHALL have ports: adr_wyniku  out  14  result memory address.

Function
REQ-015 SHALL compute y[n] = sum h[k]*x[n-k] for n = 0..M-1 and k = 0..K(n), where K(n) = min(n, N-1); no reads for n-k<0.
REQ-016 SHALL detect a Start rising edge as: Start=1 this cycle and Start=0 in the previous cycle (registered copy; reset value 0).
REQ-017 SHALL implement states IDLE, CLEAR, MAC, DRAIN, WRITE, FIN; reset state is IDLE.
REQ-018 IDLE: on a Start edge, SHALL latch N and M, set n=0 and k=0, then go to CLEAR; if the latched N=0 or M=0, SHALL go to FIN instead.
REQ-019 CLEAR: SHALL assert mac_clr for 1 cycle, set k=0, then go to MAC.
REQ-020 MAC: each cycle SHALL assert rd_en with adr_wsp=k and adr_probki=n-k, then increment k; after the cycle with k=K(n), SHALL go to DRAIN.
REQ-021 mac_en SHALL be rd_en delayed by exactly 1 cycle, so it is high during MAC cycles 2..K+1 and the DRAIN cycle.
REQ-022 DRAIN: SHALL keep rd_en=0 for 1 cycle, then go to WRITE.
REQ-023 WRITE: SHALL assert wr_wynik for 1 cycle with adr_wyniku=n; if n=M-1, SHALL go to FIN; otherwise SHALL increment n and go to CLEAR.
REQ-024 FIN: SHALL assert DONE for exactly 1 cycle with Pracuje=0, then go to IDLE.
REQ-025 Per-sample cost SHALL be K(n)+4 cycles.
REQ-026 Pracuje SHALL be 1 in CLEAR, MAC, DRAIN and WRITE, and 0 in IDLE and FIN.
REQ-027 SHALL ignore Start edges outside IDLE and SHALL NOT restart; a Start level still high on return to IDLE SHALL NOT retrigger.
REQ-028 Changes to Ile_wsp or Ile_probek after the latch SHALL have no effect until the next run.
REQ-029 n-k subtraction SHALL be 14-bit unsigned and never negative by construction.
REQ-030 rd_en, mac_clr, mac_en, wr_wynik and DONE SHALL be registered outputs, and no two of mac_clr, wr_wynik, DONE SHALL be high in the same cycle.

Reset
REQ-031 On rst_n=0, at any time including mid-run, SHALL asynchronously force: state=IDLE, all outputs=0, all addresses=0, counters=0, and the Start edge register=0.
REQ-032 After reset release, SHALL require a fresh Start rising edge; a Start held high across reset SHALL NOT trigger.

Verification
REQ-033 N=3, M=4, Start edge in cycle 0 -> CLEAR in cycle 1; rd_en counts per sample 1,2,3,3 (9 total); writes to adr_wyniku 0,1,2,3; Pracuje high in cycles 1..21; DONE in cycle 22 only.
REQ-034 N=3, n=2 address sequence -> (adr_wsp, adr_probki) = (0,2), (1,1), (2,0); mac_en high on the 3 cycles following each rd_en.
REQ-035 N=0, M=5, Start edge -> DONE pulse in cycle 1; no rd_en, no wr_wynik; Pracuje stays 0.
REQ-036 Second Start edge during a run, and Start held high after DONE -> exactly one run and one DONE.
REQ-037 rst_n low during MAC of N=63, M=100, then released, then Start edge -> outputs 0 immediately at reset; the new run begins at n=0 with the newly latched N and M.
REQ-038 N=63, M=16383 -> final wr_wynik at adr_wyniku=16382; no address wrap; DONE once.

Source files
------------

// File: rtl/fir_ctrl_fsm.sv
// Sequencer for a single-MAC FIR engine: walks y[n] = sum h[k]*x[n-k],
// driving memory reads, MAC control and result writes.
module fir_ctrl_fsm (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [5:0]  Ile_wsp,
  input  logic [13:0] Ile_probek,
  output logic        Pracuje,
  output logic        DONE,
  output logic        rd_en,
  output logic [13:0] adr_probki,
  output logic [5:0]  adr_wsp,
  output logic        mac_clr,
  output logic        mac_en,
  output logic        wr_wynik,
  output logic [13:0] adr_wyniku
);

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, WRITE, FIN} state_t;

  state_t      state, state_next;
  logic        start_q, armed, start_edge;
  logic [5:0]  n_coef, n_coef_next;
  logic [13:0] m_smp, m_smp_next;
  logic [13:0] n_idx, n_idx_next;
  logic [5:0]  k, k_next;
  logic [5:0]  n_lim, k_max;

  // armed blocks a Start level that was already high when reset released
  assign start_edge = Start & ~start_q & armed;
  assign n_lim      = n_coef - 6'd1;
  assign k_max      = (n_idx < {8'd0, n_lim}) ? n_idx[5:0] : n_lim;

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      armed   <= 1'b0;
      n_coef  <= '0;
      m_smp   <= '0;
      n_idx   <= '0;
      k       <= '0;
    end else begin
      state   <= state_next;
      start_q <= Start;
      armed   <= armed | ~Start;
      n_coef  <= n_coef_next;
      m_smp   <= m_smp_next;
      n_idx   <= n_idx_next;
      k       <= k_next;
    end
  end

  always_comb begin
    state_next  = state;
    n_coef_next = n_coef;
    m_smp_next  = m_smp;
    n_idx_next  = n_idx;
    k_next      = k;
    case (state)
      IDLE: begin
        if (start_edge) begin
          n_coef_next = Ile_wsp;
          m_smp_next  = Ile_probek;
          n_idx_next  = '0;
          k_next      = '0;
          state_next  = (Ile_wsp == 6'd0 || Ile_probek == 14'd0) ? FIN : CLEAR;
        end
      end
      CLEAR: begin
        k_next     = '0;
        state_next = MAC;
      end
      MAC: begin
        // k returns to 0 on exit so n-k can never wrap outside MAC
        if (k == k_max) begin
          k_next     = '0;
          state_next = DRAIN;
        end else begin
          k_next = k + 6'd1;
        end
      end
      DRAIN: state_next = WRITE;
      WRITE: begin
        if (n_idx == m_smp - 14'd1) begin
          state_next = FIN;
        end else begin
          n_idx_next = n_idx + 14'd1;
          state_next = CLEAR;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      Pracuje    <= 1'b0;
      DONE       <= 1'b0;
      rd_en      <= 1'b0;
      mac_clr    <= 1'b0;
      mac_en     <= 1'b0;
      wr_wynik   <= 1'b0;
      adr_wsp    <= '0;
      adr_probki <= '0;
      adr_wyniku <= '0;
    end else begin
      Pracuje    <= state_next inside {CLEAR, MAC, DRAIN, WRITE};
      DONE       <= (state_next == FIN);
      rd_en      <= (state_next == MAC);
      mac_clr    <= (state_next == CLEAR);
      mac_en     <= rd_en;
      wr_wynik   <= (state_next == WRITE);
      adr_wsp    <= k_next;
      adr_probki <= n_idx_next - {8'd0, k_next};
      adr_wyniku <= n_idx_next;
    end
  end

endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// Directed bench for fir_ctrl_fsm: replays runs against a per-sample
// address/write model and checks cycle timing, strobes and reset behaviour.
module tb_fir_ctrl_fsm;

  logic        clk_b = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  Ile_wsp = '0;
  logic [13:0] Ile_probek = '0;
  logic        Pracuje, DONE, rd_en, mac_clr, mac_en, wr_wynik;
  logic [13:0] adr_probki, adr_wyniku;
  logic [5:0]  adr_wsp;

  int checks = 0;
  int failures = 0;

  fir_ctrl_fsm dut (
    .clk_b(clk_b), .rst_n(rst_n), .Start(Start),
    .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
    .Pracuje(Pracuje), .DONE(DONE), .rd_en(rd_en),
    .adr_probki(adr_probki), .adr_wsp(adr_wsp),
    .mac_clr(mac_clr), .mac_en(mac_en), .wr_wynik(wr_wynik),
    .adr_wyniku(adr_wyniku)
  );

  always #5 clk_b = ~clk_b;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".strobes"}, {26'd0, Pracuje, DONE, rd_en, mac_clr, mac_en, wr_wynik}, 32'd0);
    checkOutput({tag, ".adr_probki"}, {18'd0, adr_probki}, 32'd0);
    checkOutput({tag, ".adr_wsp"}, {26'd0, adr_wsp}, 32'd0);
    checkOutput({tag, ".adr_wyniku"}, {18'd0, adr_wyniku}, 32'd0);
  endtask

  // mode 0: one Start pulse; 1: Start held high; 2: extra Start edge mid-run
  task automatic applyStimulus(input string tag, input int nn, input int mm, input int mode);
    int rdq[$];
    int wrq[$];
    int busy_exp, done_exp, kk, busy, dones, done_at, ev, act;
    logic prev_rd;
    busy_exp = 0; busy = 0; dones = 0; done_at = -1;
    if (nn != 0 && mm != 0) begin
      for (int n = 0; n < mm; n++) begin
        kk = (n < nn - 1) ? n : nn - 1;
        for (int k = 0; k <= kk; k++) rdq.push_back(k * 16384 + (n - k));
        wrq.push_back(n);
        busy_exp += kk + 4;
      end
    end
    done_exp = busy_exp + 1;
    @(negedge clk_b);
    Ile_wsp = 6'(nn);
    Ile_probek = 14'(mm);
    Start = 1'b1;
    prev_rd = rd_en;
    for (int c = 1; c <= done_exp + 6; c++) begin
      @(negedge clk_b);
      if (Pracuje) busy++;
      if (DONE) begin
        dones++;
        done_at = c;
        checkOutput({tag, ".done_busy"}, {31'd0, Pracuje}, 32'd0);
      end
      checkOutput({tag, ".mac_en"}, {31'd0, mac_en}, {31'd0, prev_rd});
      checkOutput({tag, ".excl"}, ($countones({mac_clr, wr_wynik, DONE}) > 1) ? 32'd1 : 32'd0, 32'd0);
      if (rd_en) begin
        ev = (rdq.size() > 0) ? rdq.pop_front() : -1;
        act = {12'd0, adr_wsp, adr_probki};
        checkOutput({tag, ".rd_adr"}, act, ev);
      end
      if (wr_wynik) begin
        ev = (wrq.size() > 0) ? wrq.pop_front() : -1;
        checkOutput({tag, ".wr_adr"}, {18'd0, adr_wyniku}, ev);
      end
      prev_rd = rd_en;
      if (c == 2) begin
        Ile_wsp = 6'(nn ^ 42);
        Ile_probek = 14'(mm ^ 7);
      end
      if (mode != 1 && c == 1) Start = 1'b0;
      if (mode == 2 && c == 6) Start = 1'b1;
      if (mode == 2 && c == 8) Start = 1'b0;
    end
    checkOutput({tag, ".done_count"}, dones, 1);
    checkOutput({tag, ".done_cycle"}, done_at, done_exp);
    checkOutput({tag, ".busy_cycles"}, busy, busy_exp);
    checkOutput({tag, ".rd_missing"}, rdq.size(), 0);
    checkOutput({tag, ".wr_missing"}, wrq.size(), 0);
    Start = 1'b0;
    repeat (2) @(negedge clk_b);
  endtask

  initial begin
    #3;
    checkAllZero("reset");
    repeat (2) @(negedge clk_b);
    rst_n = 1'b1;

    applyStimulus("n3m4", 3, 4, 0);
    applyStimulus("n0m5", 0, 5, 0);
    applyStimulus("n3m0", 3, 0, 0);
    applyStimulus("restart", 2, 6, 2);
    applyStimulus("hold", 4, 3, 1);
    applyStimulus("n1m5", 1, 5, 0);
    applyStimulus("n63m66", 63, 66, 0);

    // Abort a long run in MAC, keeping Start high across the reset
    @(negedge clk_b);
    Ile_wsp = 6'd63;
    Ile_probek = 14'd100;
    Start = 1'b1;
    repeat (150) @(negedge clk_b);
    checkOutput("pre_rst.busy", {31'd0, Pracuje}, 32'd1);
    checkOutput("pre_rst.rd_en", {31'd0, rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkAllZero("mid_rst");
    @(negedge clk_b);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_b);
      checkOutput("held_start.busy", {31'd0, Pracuje}, 32'd0);
      checkOutput("held_start.done", {31'd0, DONE}, 32'd0);
    end
    Start = 1'b0;
    @(negedge clk_b);
    applyStimulus("post_rst", 3, 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
